rx_filter_sequencer: RTL and testbench

RX_FILTER_SEQUENCER -- requirements
Module: rx_filter_sequencer

---
 rtl/rx_filter_sequencer.sv | 176 +++++++++++++++++
 tb/tb_rx_filter_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_filter_sequencer.sv
// rx_filter_sequencer: control sequencer for a 128-tap receive FIR filter.
// Accepts one sample at a time, writes it into the circular sample RAM,
// walks the 128 taps against the coefficient RAM, then dumps the MAC result.
// Host coefficient writes are only serviced while idle.
// Optional feature: define RX_FILTER_SEQ_OVR_CNT_EN to build the saturating
// lost-sample counter behind oovr_cnt; otherwise oovr_cnt reads 0.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | ready for a sample; otherwise services a pending coeff write
// S_CFG   | one-cycle coefficient RAM write, grant to host
// S_WRITE | store accepted sample at wr_ptr, clear accumulator
// S_MAC   | tap k = 0..127: coeff[k] and sample[wr_ptr-k] read addresses
// S_FLUSH | last delayed accumulate of tap 127
// S_DUMP  | transfer accumulator to output, advance wr_ptr

module rx_filter_sequencer (
    input  logic        crx_clk,
    input  logic        rrx_rst_n,
    input  logic        erx_en,
    input  logic        isample_valid,
    output logic        osample_ready,
    output logic        osample_we,
    output logic [6:0]  osample_wr_addr,
    output logic [6:0]  osample_rd_addr,
    output logic [6:0]  ocoeff_addr,
    output logic        ocoeff_we,
    output logic [15:0] ocoeff_wdata,
    output logic        omac_clr,
    output logic        omac_en,
    output logic        omac_dump,
    output logic        ofilt_valid,
    input  logic        icfg_req,
    input  logic [6:0]  icfg_addr,
    input  logic [15:0] icfg_data,
    output logic        ocfg_gnt,
    output logic        ooverrun,
    output logic [15:0] oovr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_WRITE,
        S_MAC,
        S_FLUSH,
        S_DUMP
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [6:0] wr_ptr;
    logic [6:0] tap_k;
    logic       mac_en_q;
    logic       sample_drop;

    // State register; reset wins over everything
    always_ff @(posedge crx_clk) begin
        if (!rrx_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and Moore outputs; disable forces IDLE
    always_comb begin
        state_nxt       = state;
        osample_ready   = (state == S_IDLE) && rrx_rst_n && erx_en;
        osample_we      = 1'b0;
        osample_wr_addr = 7'd0;
        osample_rd_addr = 7'd0;
        ocoeff_addr     = 7'd0;
        ocoeff_we       = 1'b0;
        ocoeff_wdata    = 16'd0;
        omac_clr        = 1'b0;
        omac_dump       = 1'b0;
        ofilt_valid     = 1'b0;
        ocfg_gnt        = 1'b0;
        case (state)
            S_IDLE: begin
                if (isample_valid && osample_ready) begin
                    state_nxt = S_WRITE;
                end else if (icfg_req) begin
                    state_nxt = S_CFG;
                end
            end
            S_CFG: begin
                ocoeff_we    = 1'b1;
                ocoeff_addr  = icfg_addr;
                ocoeff_wdata = icfg_data;
                ocfg_gnt     = 1'b1;
                state_nxt    = S_IDLE;
            end
            S_WRITE: begin
                osample_we      = 1'b1;
                osample_wr_addr = wr_ptr;
                omac_clr        = 1'b1;
                state_nxt       = S_MAC;
            end
            S_MAC: begin
                ocoeff_addr     = tap_k;
                osample_rd_addr = wr_ptr - tap_k;
                if (tap_k == 7'd127) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_nxt = S_DUMP;
            end
            S_DUMP: begin
                omac_dump   = 1'b1;
                ofilt_valid = 1'b1;
                state_nxt   = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (!erx_en) begin
            state_nxt = S_IDLE;
        end
    end

    // Tap counter runs only in MAC; write pointer advances once per result
    always_ff @(posedge crx_clk) begin
        if (!rrx_rst_n || !erx_en) begin
            wr_ptr <= 7'd0;
            tap_k  <= 7'd0;
        end else begin
            tap_k <= (state == S_MAC) ? tap_k + 7'd1 : 7'd0;
            if (state == S_DUMP) begin
                wr_ptr <= wr_ptr + 7'd1;
            end
        end
    end

    // Accumulate strobe trails MAC occupancy by the RAM read latency
    always_ff @(posedge crx_clk) begin
        if (!rrx_rst_n) begin
            mac_en_q <= 1'b0;
        end else begin
            mac_en_q <= erx_en && (state == S_MAC);
        end
    end

    assign omac_en     = mac_en_q;
    assign sample_drop = isample_valid && !osample_ready;

    // Sticky overrun flag; survives disable, cleared only by reset
    always_ff @(posedge crx_clk) begin
        if (!rrx_rst_n) begin
            ooverrun <= 1'b0;
        end else if (sample_drop) begin
            ooverrun <= 1'b1;
        end
    end

`ifdef RX_FILTER_SEQ_OVR_CNT_EN
    logic [15:0] ovr_cnt_q;

    // Saturating count of dropped samples
    always_ff @(posedge crx_clk) begin
        if (!rrx_rst_n) begin
            ovr_cnt_q <= 16'd0;
        end else if (sample_drop && (ovr_cnt_q != 16'hFFFF)) begin
            ovr_cnt_q <= ovr_cnt_q + 16'd1;
        end
    end

    assign oovr_cnt = ovr_cnt_q;
`else
    assign oovr_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_rx_filter_sequencer.sv
// Testbench for rx_filter_sequencer: directed scenarios plus a randomized
// soak, every cycle compared against a timeline model that tracks only the
// cycle offset since the last accepted sample.
module tb_rx_filter_sequencer;

    logic        crx_clk = 1'b0;
    logic        rrx_rst_n, erx_en, isample_valid;
    logic        osample_ready, osample_we;
    logic [6:0]  osample_wr_addr, osample_rd_addr, ocoeff_addr;
    logic        ocoeff_we;
    logic [15:0] ocoeff_wdata;
    logic        omac_clr, omac_en, omac_dump, ofilt_valid;
    logic        icfg_req;
    logic [6:0]  icfg_addr;
    logic [15:0] icfg_data;
    logic        ocfg_gnt, ooverrun;
    logic [15:0] oovr_cnt;

    rx_filter_sequencer dut (
        .crx_clk(crx_clk), .rrx_rst_n(rrx_rst_n), .erx_en(erx_en),
        .isample_valid(isample_valid), .osample_ready(osample_ready),
        .osample_we(osample_we), .osample_wr_addr(osample_wr_addr),
        .osample_rd_addr(osample_rd_addr), .ocoeff_addr(ocoeff_addr),
        .ocoeff_we(ocoeff_we), .ocoeff_wdata(ocoeff_wdata),
        .omac_clr(omac_clr), .omac_en(omac_en), .omac_dump(omac_dump),
        .ofilt_valid(ofilt_valid), .icfg_req(icfg_req), .icfg_addr(icfg_addr),
        .icfg_data(icfg_data), .ocfg_gnt(ocfg_gnt), .ooverrun(ooverrun),
        .oovr_cnt(oovr_cnt)
    );

    always #5 crx_clk = ~crx_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Count one comparison and report a mismatch
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver intent (persistent across cycles)
    logic        rst_d = 1'b0;
    logic        en_d  = 1'b1;
    logic        req_d = 1'b0;
    logic [6:0]  req_addr = 7'd0;
    logic [15:0] req_data = 16'd0;

    // Reference model: 0 = idle, 1 = coefficient write cycle, 2 = sample in flight
    int m_mode = 0;
    int m_d    = 0;   // cycles since accept while in flight
    int m_ptr  = 0;
    int m_ovr  = 0;
    int m_cnt  = 0;

    // DUT observations for directed checks
    int cyc = 0;
    int valid_cyc = -1;
    int n_valid = 0;
    int n_mac_en = 0;
    int wr_log[$];

    task automatic tick(input logic v);
        bit busy, tap, drop;
        int e_ready, e_rd, e_caddr;
        @(negedge crx_clk);
        isample_valid = v;
        erx_en        = en_d;
        rrx_rst_n     = rst_d;
        icfg_req      = req_d;
        icfg_addr     = req_addr;
        icfg_data     = req_data;
        #1;
        busy    = (m_mode == 2);
        tap     = busy && (m_d >= 2) && (m_d <= 129);
        e_ready = (m_mode == 0 && en_d && rst_d) ? 1 : 0;
        e_rd    = tap ? (((m_ptr - (m_d - 2)) % 128) + 128) % 128 : 0;
        e_caddr = (m_mode == 1) ? int'(req_addr) : (tap ? m_d - 2 : 0);
        check_val("ready",    osample_ready, e_ready);
        check_val("we",       osample_we, busy && m_d == 1);
        check_val("wr_addr",  osample_wr_addr, (busy && m_d == 1) ? m_ptr : 0);
        check_val("mac_clr",  omac_clr, busy && m_d == 1);
        check_val("rd_addr",  osample_rd_addr, e_rd);
        check_val("c_addr",   ocoeff_addr, e_caddr);
        check_val("c_we",     ocoeff_we, m_mode == 1);
        check_val("c_wdata",  ocoeff_wdata, (m_mode == 1) ? int'(req_data) : 0);
        check_val("cfg_gnt",  ocfg_gnt, m_mode == 1);
        check_val("mac_en",   omac_en, busy && m_d >= 3 && m_d <= 130);
        check_val("mac_dump", omac_dump, busy && m_d == 131);
        check_val("valid",    ofilt_valid, busy && m_d == 131);
        check_val("overrun",  ooverrun, m_ovr);
        check_val("ovr_cnt",  oovr_cnt, m_cnt);

        if (ofilt_valid === 1'b1) begin valid_cyc = cyc; n_valid++; end
        if (omac_en === 1'b1) n_mac_en++;
        if (osample_we === 1'b1) wr_log.push_back(int'(osample_wr_addr));

        drop = v && (e_ready == 0);
        if (m_mode == 1) req_d = 1'b0;   // granted this cycle; requester lets go
        if (!rst_d) begin
            m_mode = 0; m_d = 0; m_ptr = 0; m_ovr = 0; m_cnt = 0;
        end else begin
            if (drop) begin
                m_ovr = 1;
`ifdef RX_FILTER_SEQ_OVR_CNT_EN
                if (m_cnt < 65535) m_cnt++;
`endif
            end
            if (!en_d) begin
                m_mode = 0; m_d = 0; m_ptr = 0;
            end else if (m_mode == 0) begin
                if (v) begin m_mode = 2; m_d = 1; end
                else if (icfg_req) m_mode = 1;
            end else if (m_mode == 1) begin
                m_mode = 0;
            end else if (m_d == 131) begin
                m_mode = 0; m_d = 0; m_ptr = (m_ptr + 1) % 128;
            end else begin
                m_d++;
            end
        end
        cyc++;
    endtask

    initial begin
        int acc_cyc;
        rrx_rst_n = 1'b0; erx_en = 1'b1; isample_valid = 1'b0;
        icfg_req = 1'b0; icfg_addr = 7'd0; icfg_data = 16'd0;

        // Reset, then one sample
        repeat (3) tick(0);
        rst_d = 1'b1;
        repeat (2) tick(0);
        n_mac_en = 0; valid_cyc = -1; wr_log.delete();
        acc_cyc = cyc;
        tick(1);
        repeat (140) tick(0);
        check_val("latency", valid_cyc - acc_cyc, 131);
        check_val("mac_en_count", n_mac_en, 128);
        check_val("first_wr_addr", (wr_log.size() > 0) ? wr_log[0] : -1, 0);

        // Reset to put wr_ptr back at 0, then a train of 130 samples
        rst_d = 1'b0; tick(0); rst_d = 1'b1; tick(0);
        wr_log.delete();
        for (int i = 0; i < 130; i++) begin
            tick(1);
            repeat (131) tick(0);
        end
        check_val("train_writes", wr_log.size(), 130);
        for (int i = 0; i < wr_log.size() && i < 130; i++)
            check_val("train_addr", wr_log[i], i % 128);
        check_val("train_no_ovr", ooverrun, 0);

        // Overrun: second sample at accept+50
        valid_cyc = -1; acc_cyc = cyc;
        tick(1);
        repeat (49) tick(0);
        tick(1);
        repeat (90) tick(0);
        check_val("ovr_latency", valid_cyc - acc_cyc, 131);

        // Coefficient write from idle, then simultaneous with a sample
        req_d = 1'b1; req_addr = 7'd5; req_data = 16'h1234;
        repeat (4) tick(0);
        req_d = 1'b1; req_addr = 7'd9; req_data = 16'hBEEF;
        tick(1);
        repeat (135) tick(0);
        check_val("cfg_released", req_d, 0);

        // Abort at accept+60
        n_valid = 0;
        tick(1);
        repeat (59) tick(0);
        en_d = 1'b0; tick(0); en_d = 1'b1;
        repeat (140) tick(0);
        check_val("abort_no_valid", n_valid, 0);
        wr_log.delete();
        tick(1);
        repeat (3) tick(0);
        check_val("abort_wr_addr", (wr_log.size() > 0) ? wr_log[0] : -1, 0);

        // Reset mid-MAC after an overrun
        repeat (20) tick(0);
        tick(1);
        repeat (30) tick(0);
        rst_d = 1'b0; tick(0); rst_d = 1'b1;
        repeat (5) tick(0);

        // Randomized soak
        for (int i = 0; i < 5000; i++) begin
            en_d  = ($urandom_range(399) != 0);
            rst_d = ($urandom_range(1499) != 0);
            if (!req_d && $urandom_range(24) == 0) begin
                req_d = 1'b1;
                req_addr = 7'($urandom_range(127));
                req_data = 16'($urandom_range(65535));
            end
            tick($urandom_range(39) == 0);
        end
        rst_d = 1'b1; en_d = 1'b1;
        repeat (2) tick(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
